// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared sizes and state encoding for the post-processing drain unit
package ppu_pkg;

   localparam int PPU_ROWS  = 16;
   localparam int PPU_LANES = 16;
   localparam int PPU_ACC_W = 24;
   localparam int PPU_Q_W   = 8;
   localparam int PPU_OUT_W = PPU_LANES * PPU_Q_W;
   localparam int PPU_INT4_W = 4;
   localparam int PPU_SAT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/ppu_lane_quant.sv
// rtl/ppu_lane_quant.sv - one lane of round-half-up, arithmetic shift and saturate
// int4 results sit sign-consistent in the low nibble of q.
module ppu_lane_quant
   import ppu_pkg::*;
#(
   parameter int ACC_W = PPU_ACC_W
) (
   input  logic [ACC_W-1:0]   acc,
   input  logic [4:0]         shift_amt,
   input  logic               int4,
   output logic [PPU_Q_W-1:0] q,
   output logic               sat
);

   logic signed [ACC_W:0] wide;
   logic signed [ACC_W:0] rounded;
   logic signed [ACC_W:0] shifted;
   logic signed [ACC_W:0] hi;
   logic signed [ACC_W:0] lo;
   logic [4:0]            s;

   // One extra bit of headroom so the rounding add can never wrap.
   always_comb begin
      s       = (shift_amt > 5'(ACC_W-1)) ? 5'(ACC_W-1) : shift_amt;
      wide    = $signed({acc[ACC_W-1], acc});
      rounded = wide;
      if (s != 5'd0) begin
         rounded = wide + ((ACC_W+1)'(1) <<< (s - 5'd1));
      end
      shifted = rounded >>> s;
      hi      = int4 ? (ACC_W+1)'(7)  : (ACC_W+1)'(127);
      lo      = int4 ? -(ACC_W+1)'(8) : -(ACC_W+1)'(128);
      sat     = 1'b0;
      q       = shifted[PPU_Q_W-1:0];
      if (shifted > hi) begin
         q   = hi[PPU_Q_W-1:0];
         sat = 1'b1;
      end else if (shifted < lo) begin
         q   = lo[PPU_Q_W-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/ppu_drain.sv
// rtl/ppu_drain.sv - buffers one accumulator tile, then drains it quantized row by row
// Format and shift are captured with row 0 and hold for the whole tile.
module ppu_drain
   import ppu_pkg::*;
#(
   parameter int ROWS  = PPU_ROWS,
   parameter int LANES = PPU_LANES,
   parameter int ACC_W = PPU_ACC_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       row_valid,
   input  logic [LANES*ACC_W-1:0]     row_in,
   input  logic                       is_int8_mode,
   input  logic                       is_int4_mode,
   input  logic [4:0]                 shift_amt,
   output logic [LANES*PPU_Q_W-1:0]   out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last,
   output logic                       busy,
   output logic                       done,
   output logic                       drop_err,
   output logic [PPU_SAT_W-1:0]       sat_cnt
);

   localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CNT_W = $clog2(LANES + 1);
   localparam int ROW_W = LANES * ACC_W;
   localparam int OUT_W = LANES * PPU_Q_W;

   state_t                 state;
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_addr;
   logic                   wr_en;
   logic [ROW_W-1:0]       row_buf [ROWS];
   logic [ROW_W-1:0]       rd_row;
   logic                   fmt_int4;
   logic [4:0]             shift_lat;
   logic [OUT_W-1:0]       q_flat;
   logic [LANES-1:0]       lane_sat;
   logic [OUT_W-1:0]       packed_row;
   logic [CNT_W-1:0]       sat_row;
   logic [PPU_SAT_W:0]     sat_sum;
   logic [PPU_SAT_W-1:0]   sat_next;
   logic                   handshake;

   assign wr_en     = row_valid && (state != ST_DRAIN);
   assign wr_addr   = (state == ST_IDLE) ? '0 : wr_ptr;
   assign rd_row    = row_buf[rd_ptr];
   assign handshake = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         row_buf[wr_addr] <= row_in;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      ppu_lane_quant #(.ACC_W(ACC_W)) u_quant (
         .acc       (rd_row[i*ACC_W +: ACC_W]),
         .shift_amt (shift_lat),
         .int4      (fmt_int4),
         .q         (q_flat[i*PPU_Q_W +: PPU_Q_W]),
         .sat       (lane_sat[i])
      );
   end

   always_comb begin
      packed_row = '0;
      sat_row    = '0;
      for (int i = 0; i < LANES; i++) begin
         if (fmt_int4) begin
            packed_row[i*PPU_INT4_W +: PPU_INT4_W] = q_flat[i*PPU_Q_W +: PPU_INT4_W];
         end else begin
            packed_row[i*PPU_Q_W +: PPU_Q_W] = q_flat[i*PPU_Q_W +: PPU_Q_W];
         end
         sat_row = sat_row + CNT_W'(lane_sat[i]);
      end
      sat_sum  = {1'b0, sat_cnt} + (PPU_SAT_W+1)'(sat_row);
      sat_next = sat_sum[PPU_SAT_W] ? {PPU_SAT_W{1'b1}} : sat_sum[PPU_SAT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         drop_err  <= 1'b0;
         sat_cnt   <= '0;
         fmt_int4  <= 1'b0;
         shift_lat <= '0;
      end else begin
         done     <= 1'b0;
         drop_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (row_valid) begin
                  fmt_int4  <= is_int4_mode && !is_int8_mode;
                  shift_lat <= shift_amt;
                  sat_cnt   <= '0;
                  wr_ptr    <= PTR_W'(1);
                  busy      <= 1'b1;
                  state     <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (row_valid) begin
                  wr_ptr <= wr_ptr + PTR_W'(1);
                  // Row 0 is already in the buffer, so it can be presented on the
                  // same edge that captures the final row.
                  if (wr_ptr == PTR_W'(ROWS-1)) begin
                     wr_ptr    <= '0;
                     out_data  <= packed_row;
                     out_valid <= 1'b1;
                     out_last  <= (ROWS == 1);
                     sat_cnt   <= sat_next;
                     rd_ptr    <= PTR_W'(1);
                     state     <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               drop_err <= row_valid;
               if (handshake) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     rd_ptr    <= '0;
                     state     <= ST_IDLE;
                  end else begin
                     out_data <= packed_row;
                     out_last <= (rd_ptr == PTR_W'(ROWS-1));
                     sat_cnt  <= sat_next;
                     rd_ptr   <= rd_ptr + PTR_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ppu_drain.sv
// tb/tb_ppu_drain.sv - randomized tiles against a transaction-level quantization model
module tb_ppu_drain;

   localparam int ROWS  = 16;
   localparam int LANES = 16;
   localparam int ACC_W = 24;
   localparam int ROW_W = LANES * ACC_W;
   localparam int MAX_CYCLES = 40000;

   typedef struct {
      int kind;
      int ready_mode;
      bit strays;
   } plan_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             row_valid = 1'b0;
   logic [ROW_W-1:0] row_in = '0;
   logic             is_int8_mode = 1'b0;
   logic             is_int4_mode = 1'b0;
   logic [4:0]       shift_amt = '0;
   logic [127:0]     out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_last;
   logic             busy;
   logic             done;
   logic             drop_err;
   logic [7:0]       sat_cnt;

   ppu_drain #(.ROWS(ROWS), .LANES(LANES), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .row_valid(row_valid), .row_in(row_in),
      .is_int8_mode(is_int8_mode), .is_int4_mode(is_int4_mode), .shift_amt(shift_amt),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done), .drop_err(drop_err), .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic void qmodel(input logic [23:0] acc, input int sh, input bit int4,
                                  output logic [7:0] q, output bit sat);
      int v, s, hi, lo;
      s = (sh > 23) ? 23 : sh;
      v = $signed(acc);
      if (s > 0) v = v + (1 << (s - 1));
      v = v >>> s;
      hi = int4 ? 7 : 127;
      lo = int4 ? -8 : -128;
      sat = 1'b0;
      if (v > hi) begin v = hi; sat = 1'b1; end
      else if (v < lo) begin v = lo; sat = 1'b1; end
      q = v[7:0];
   endfunction

   // Model state: what the tile must look like once it is complete.
   logic [ROW_W-1:0] m_buf [ROWS];
   logic [127:0]     e_row [ROWS];
   int               e_sat [ROWS];
   bit               m_int4;
   int               m_shift;
   bit               m_drain;
   int               m_rows;
   int               m_hs;
   int               dut_hs;
   bit               exp_valid, exp_done, exp_drop, exp_busy;
   int               exp_sat;
   int               done_kind;
   plan_t            plans [$];
   int               pi;

   task automatic build_tile();
      int acc_sat;
      logic [7:0] q;
      bit s;
      acc_sat = 0;
      for (int r = 0; r < ROWS; r++) begin
         e_row[r] = '0;
         for (int l = 0; l < LANES; l++) begin
            qmodel(m_buf[r][l*ACC_W +: ACC_W], m_shift, m_int4, q, s);
            if (m_int4) e_row[r][l*4 +: 4] = q[3:0];
            else        e_row[r][l*8 +: 8] = q;
            if (s) acc_sat++;
         end
         if (acc_sat > 255) acc_sat = 255;
         e_sat[r] = acc_sat;
      end
   endtask

   function automatic logic [ROW_W-1:0] gen_row(input int kind);
      logic [ROW_W-1:0] r;
      int v;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         case (kind)
            1: r[l*ACC_W +: ACC_W] = 24'h000100;
            2: r[l*ACC_W +: ACC_W] = (l == 0) ? 24'h7FFFFF : (l == 1) ? 24'hFFF000 : 24'h0;
            3: r[l*ACC_W +: ACC_W] = (l % 2 == 0) ? 24'd24 : 24'd30;
            default: begin
               case ($urandom_range(0, 7))
                  0: r[l*ACC_W +: ACC_W] = 24'h7FFFFF;
                  1: r[l*ACC_W +: ACC_W] = 24'h800000;
                  2, 3: r[l*ACC_W +: ACC_W] = 24'($urandom());
                  default: begin
                     v = int'($urandom_range(0, 4095)) - 2048;
                     v = v <<< $urandom_range(0, 10);
                     r[l*ACC_W +: ACC_W] = v[23:0];
                  end
               endcase
            end
         endcase
      end
      return r;
   endfunction

   task automatic check_outputs();
      chk("out_valid", out_valid, exp_valid);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("drop_err", drop_err, exp_drop);
      chk("sat_cnt", sat_cnt, 128'(exp_sat));
      if (exp_valid) begin
         chk($sformatf("out_data row %0d", m_hs), out_data, e_row[m_hs]);
         chk($sformatf("out_last row %0d", m_hs), out_last, (m_hs == ROWS - 1));
         if (m_hs == 0) begin
            case (plans[pi].kind)
               1: chk("literal int8 row", out_data, {16{8'h10}});
               2: chk("literal sat row", out_data, 128'h807F);
               3: chk("literal int4 row", out_data, {64'h0, {8{8'h76}}});
               default: ;
            endcase
         end
      end
      if (exp_done) begin
         chk("handshakes per tile", 128'(dut_hs), 128'(ROWS));
         case (done_kind)
            1: chk("literal sat_cnt zero", sat_cnt, 128'd0);
            2: chk("literal sat_cnt 2 per row", sat_cnt, 128'd32);
            3: chk("literal sat_cnt int4", sat_cnt, 128'd128);
            default: ;
         endcase
      end
   endtask

   task automatic model_reset();
      m_drain = 0; m_rows = 0; m_hs = 0; dut_hs = 0;
      exp_valid = 0; exp_done = 0; exp_drop = 0; exp_busy = 0; exp_sat = 0;
   endtask

   task automatic drive_cycle();
      plan_t p;
      bit hs;
      rst = 1'b0;
      p = plans[pi];
      case (p.ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = ~out_ready;
         default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (out_valid && out_ready) dut_hs++;
      is_int8_mode = 1'($urandom());
      is_int4_mode = 1'($urandom());
      shift_amt    = 5'($urandom());
      row_in       = gen_row(0);
      exp_done = 0;
      exp_drop = 0;
      if (!m_drain) begin
         row_valid = ($urandom_range(0, 99) < 80);
         if (row_valid) begin
            row_in = gen_row(p.kind);
            if (m_rows == 0) begin
               case (p.kind)
                  1, 2: begin shift_amt = 5'd0; is_int8_mode = 1'b1; is_int4_mode = 1'b0; end
                  3: begin shift_amt = 5'd2; is_int8_mode = 1'b0; is_int4_mode = 1'b1; end
                  default: ;
               endcase
               if (p.kind == 1) shift_amt = 5'd4;
               m_int4 = is_int4_mode && !is_int8_mode;
               m_shift = int'(shift_amt);
               exp_sat = 0;
               exp_busy = 1;
               dut_hs = 0;
            end
            m_buf[m_rows] = row_in;
            m_rows++;
            if (m_rows == ROWS) begin
               build_tile();
               m_drain = 1;
               m_hs = 0;
               exp_valid = 1;
               exp_sat = e_sat[0];
            end
         end
      end else begin
         hs = exp_valid && out_ready;
         row_valid = p.strays && ($urandom_range(0, 9) == 0);
         exp_drop = row_valid;
         if (hs) begin
            if (m_hs == ROWS - 1) begin
               exp_valid = 0;
               exp_done = 1;
               exp_busy = 0;
               m_drain = 0;
               m_rows = 0;
               done_kind = p.kind;
               pi++;
            end else begin
               m_hs++;
               exp_sat = e_sat[m_hs];
            end
         end
      end
   endtask

   initial begin
      logic [7:0] q;
      bit s;
      int cycles;
      qmodel(24'h000100, 4, 0, q, s);  chk("model 0x100>>4", {s, q}, {1'b0, 8'h10});
      qmodel(24'h7FFFFF, 0, 0, q, s);  chk("model int8 max", {s, q}, {1'b1, 8'h7F});
      qmodel(24'hFFF000, 0, 0, q, s);  chk("model int8 min", {s, q}, {1'b1, 8'h80});
      qmodel(24'd24, 2, 1, q, s);      chk("model int4 24", {s, q[3:0]}, {1'b0, 4'h6});
      qmodel(24'd30, 2, 1, q, s);      chk("model int4 30", {s, q[3:0]}, {1'b1, 4'h7});
      qmodel(24'hFFFFFF, 31, 0, q, s); chk("model shift clamp", {s, q}, {1'b0, 8'h00});

      plans.push_back('{1, 0, 0});
      plans.push_back('{2, 0, 0});
      plans.push_back('{3, 0, 0});
      plans.push_back('{1, 1, 0});
      plans.push_back('{1, 0, 1});
      plans.push_back('{4, 2, 0});
      plans.push_back('{1, 2, 1});
      for (int i = 0; i < 20; i++) plans.push_back('{0, $urandom_range(0, 2), 1'b1});

      model_reset();
      done_kind = 0;
      pi = 0;
      cycles = 0;
      @(negedge clk);
      check_outputs();
      chk("reset out_data", out_data, 128'd0);
      chk("reset out_last", out_last, 1'b0);
      rst = 1'b0;
      while (pi < plans.size() && cycles < MAX_CYCLES) begin
         if (!m_drain && plans[pi].kind == 4 && m_rows == 8) begin
            rst = 1'b1;
            row_valid = 1'b0;
            #1;
            chk("mid-tile reset out_valid", out_valid, 1'b0);
            chk("mid-tile reset out_last", out_last, 1'b0);
            chk("mid-tile reset out_data", out_data, 128'd0);
            chk("mid-tile reset busy", busy, 1'b0);
            chk("mid-tile reset done", done, 1'b0);
            chk("mid-tile reset drop_err", drop_err, 1'b0);
            chk("mid-tile reset sat_cnt", sat_cnt, 128'd0);
            model_reset();
            done_kind = 0;
            pi++;
         end else begin
            drive_cycle();
         end
         @(negedge clk);
         cycles++;
         check_outputs();
      end
      if (pi < plans.size()) chk("tile completion within cycle budget", 128'(pi), 128'(plans.size()));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ppu_drain.md
PPU_DRAIN -- requirements
Module: ppu_drain

Interface
REQ-001 SHALL have parameter ROWS, default 16, rows per accumulator tile.
REQ-002 SHALL have parameter LANES, default 16, 24-bit lanes per row.
REQ-003 SHALL have parameter ACC_W, default 24, signed accumulator width per lane.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port row_valid  input  1  row_in carries one accumulator row this cycle; no backpressure.
REQ-007 SHALL have port row_in  input  LANES*ACC_W (384)  lane i at bits [24i+23:24i], signed.
REQ-008 SHALL have port is_int8_mode  input  1  int8 output format, sampled with row 0.
REQ-009 SHALL have port is_int4_mode  input  1  int4 output format, sampled with row 0.
REQ-010 SHALL have port shift_amt  input  5  right-shift amount, sampled with row 0.
REQ-011 SHALL have port out_data  output  128  quantized row.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts when out_valid&&out_ready.
REQ-014 SHALL have port out_last  output  1  out_data is row ROWS-1.
REQ-015 SHALL have port busy  output  1  high in FILL or DRAIN.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last row accepted.
REQ-017 SHALL have port drop_err  output  1  one-cycle pulse when a row_valid is discarded.
REQ-018 SHALL have port sat_cnt  output  8  lanes saturated in current tile, saturating at 255.

Function
REQ-019 SHALL implement FSM IDLE, FILL, DRAIN.
REQ-020 IDLE + row_valid: SHALL store row 0, latch format/shift_amt, clear sat_cnt, wr_ptr<=1, go FILL.
REQ-021 FILL + row_valid: SHALL store row at wr_ptr, wr_ptr++; gaps in row_valid allowed; storing row ROWS-1 -> DRAIN.
REQ-022 DRAIN entry: SHALL load quantized row 0 into output register; out_valid high the first DRAIN cycle (1 cycle after row ROWS-1 captured).
REQ-023 On out_valid&&out_ready SHALL load next row into output register same edge (back-to-back, no bubble); out_valid/out_data SHALL hold stable while out_ready low.
REQ-024 Handshake of row ROWS-1 (out_last=1): SHALL drop out_valid, pulse done next cycle, return IDLE.
REQ-025 row_valid in DRAIN SHALL be discarded and pulse drop_err next cycle; buffer unchanged.
REQ-026 Lane quantization: s=min(shift_amt,23); if s>0 add 2^(s-1); arithmetic shift right s; ACC_W+1 bit intermediate, no wrap.
REQ-027 int4 when is_int4_mode && !is_int8_mode: saturate to [-8,7], lane i at out_data[4i+3:4i], bits [127:64]=0.
REQ-028 Otherwise int8: saturate to [-128,127], lane i at out_data[8i+7:8i].
REQ-029 sat_cnt SHALL add the number of clipped lanes of each row loaded into output register, clamping at 255.
REQ-030 Format/shift changes after row 0 SHALL not affect the tile.

Reset
REQ-031 rst SHALL force IDLE, wr_ptr=0, rd_ptr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, drop_err=0, sat_cnt=0 immediately.
REQ-032 Row buffer contents need no reset; rst mid-FILL/DRAIN SHALL abandon the tile, no done pulse.

Structure
REQ-033 Package ppu_pkg SHALL hold ROWS, LANES, ACC_W, out widths, state encoding.
REQ-034 Sub-module ppu_lane_quant SHALL perform one lane round/shift/saturate, instantiated LANES times.
REQ-035 Row buffer SHALL be ROWS x 384 register array, single write, single read port.

Verification
REQ-036 16 rows, all lanes 0x000100, shift 4, int8, out_ready=1 -> 16 rows each lane 0x10, out_last on 16th, done 1 cycle later, sat_cnt=0.
REQ-037 Lane 0 = 0x7FFFFF, lane 1 = 0xFFF000, shift 0, int8 -> lane0 0x7F, lane1 0x80, sat_cnt increments by 2 per row.
REQ-038 int4, lanes = 24 (0x000018), shift 2 -> nibble 0x6; lanes = 30 -> 0x7 saturated; out_data[127:64]=0.
REQ-039 out_ready toggled 1/0 each cycle -> out_data stable while stalled, exactly 16 handshakes, order preserved.
REQ-040 row_valid pulsed during DRAIN -> drop_err pulse, output rows unchanged.
REQ-041 rst asserted after 8 rows captured -> outputs at reset values, next 16-row tile processed normally.
